// File: rtl/gpio_apb_pkg.sv
// Shared register map, ID constant and bus FSM encoding for the APB GPIO completer.
package gpio_apb_pkg;

    localparam logic [7:0] OFF_DATA_OUT   = 8'h00;
    localparam logic [7:0] OFF_DIR        = 8'h04;
    localparam logic [7:0] OFF_DATA_IN    = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN     = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h10;
    localparam logic [7:0] OFF_EDGE_SEL   = 8'h14;
    localparam logic [7:0] OFF_ID         = 8'h30;

    localparam logic [31:0] ID_VALUE = 32'h4750_494F;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETUP  = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;

    function automatic logic offset_known(input logic [7:0] off);
        case (off)
            OFF_DATA_OUT, OFF_DIR, OFF_DATA_IN, OFF_IRQ_EN,
            OFF_IRQ_STATUS, OFF_EDGE_SEL, OFF_ID: offset_known = 1'b1;
            default:                              offset_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// Pin synchroniser, edge detector and sticky interrupt status with W1C clear.
module gpio_edge_sync
    import gpio_apb_pkg::*;
#(
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] edge_sel,
    input  logic [GPIO_W-1:0] clr_mask,
    input  logic              clr_en,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] data_in,
    output logic [GPIO_W-1:0] status
);

    logic [GPIO_W-1:0] sync1_q, sync2_q, prev_q;
    logic [GPIO_W-1:0] status_q, status_d;
    logic [GPIO_W-1:0] rise, fall, hit, clr;

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;
    assign hit  = (rise & edge_sel) | (fall & ~edge_sel);
    assign clr  = clr_mask & {GPIO_W{clr_en}};

    // Edge set is OR-ed after the clear so a coincident edge survives the W1C.
    assign status_d = (status_q & ~clr) | hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            status_q <= '0;
        end else begin
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            status_q <= status_d;
        end
    end

    assign data_in = sync2_q;
    assign status  = status_q;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 completer for a GPIO block: wait-state bus FSM, register file and error decode.
//   state  | meaning
//   IDLE   | no transfer; waiting for a setup phase (PSEL=1, PENABLE=0)
//   SETUP  | setup seen; current cycle is the first access cycle
//   ACCESS | counting down wait states until the completing cycle
module apb_gpio_slave
    import gpio_apb_pkg::*;
#(
    parameter int GPIO_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [31:0]       PADDR,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       prdata_q, prdata_d;
    logic [GPIO_W-1:0] data_out_q, data_out_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [GPIO_W-1:0] irq_en_q, irq_en_d;
    logic [GPIO_W-1:0] edge_sel_q, edge_sel_d;
    logic [GPIO_W-1:0] data_in, status, wdata;
    logic [7:0]        offset;
    logic              addr_err, commit, clr_en;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign offset      = {PADDR[7:2], 2'b00};
    assign addr_err    = (PADDR[31:8] != 24'd0) || !offset_known(offset);
    assign wdata       = PWDATA[GPIO_W-1:0];
    assign commit      = pready_q && !pslverr_q && PSEL && PENABLE && PWRITE;
    assign clr_en      = commit && (offset == OFF_IRQ_STATUS);
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    gpio_edge_sync #(.GPIO_W(GPIO_W)) u_edge_sync (
        .clk      (PCLK),
        .rst      (PRESET),
        .edge_sel (edge_sel_q),
        .clr_mask (wdata),
        .clr_en   (clr_en),
        .gpio_in  (gpio_in),
        .data_in  (data_in),
        .status   (status)
    );

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_DATA_OUT:   rdata[GPIO_W-1:0] = data_out_q;
            OFF_DIR:        rdata[GPIO_W-1:0] = dir_q;
            OFF_DATA_IN:    rdata[GPIO_W-1:0] = data_in;
            OFF_IRQ_EN:     rdata[GPIO_W-1:0] = irq_en_q;
            OFF_IRQ_STATUS: rdata[GPIO_W-1:0] = status;
            OFF_EDGE_SEL:   rdata[GPIO_W-1:0] = edge_sel_q;
            OFF_ID:         rdata = ID_VALUE;
            default:        rdata = '0;
        endcase
        if (addr_err) rdata = '0;
    end

    // PREADY is registered, so it is raised one edge ahead of the completing cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = SETUP;
                    cnt_d    = WS;
                    pready_d = (WS == 4'd0);
                end
            end
            SETUP, ACCESS: begin
                if (!PSEL || !PENABLE || pready_q) begin
                    state_d = IDLE;
                end else begin
                    state_d  = ACCESS;
                    cnt_d    = cnt_q - 4'd1;
                    pready_d = (cnt_q == 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
        prdata_d  = pready_d ? rdata : 32'd0;
        pslverr_d = pready_d && addr_err;
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        edge_sel_d = edge_sel_q;
        if (commit) begin
            case (offset)
                OFF_DATA_OUT: data_out_d = wdata;
                OFF_DIR:      dir_d      = wdata;
                OFF_IRQ_EN:   irq_en_d   = wdata;
                OFF_EDGE_SEL: edge_sel_d = wdata;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            edge_sel_q <= edge_sel_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(status & irq_en_q);

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: a register-level model checked every cycle, plus literal pins.
module tb_apb_gpio_slave;

    localparam int GW = 8;
    localparam int WS = 1;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          PSEL = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE = 1'b0;
    logic [31:0]   PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [GW-1:0] gpio_in = '0;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_oe;
    logic          irq;

    always #5 PCLK = ~PCLK;

    apb_gpio_slave #(.GPIO_W(GW), .WAIT_STATES(WS)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;
    bit in_xfer = 1'b0;
    logic [31:0] rd;
    logic        err;

    // Register-level model: register values, sampled pin history, pending committed write.
    logic [GW-1:0] m_data_out, m_dir, m_irq_en, m_edge_sel, m_status;
    logic [GW-1:0] m_pins [3];
    logic [GW-1:0] m_hits, m_clr;
    bit            m_pend = 1'b0;
    logic [7:0]    m_pend_off;
    logic [GW-1:0] m_pend_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a);
        logic [7:0] off;
        off = {a[7:2], 2'b00};
        if (a[31:8] != 24'd0) return 1'b1;
        return !(off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h30});
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (m_err(a)) return v;
        case ({a[7:2], 2'b00})
            8'h00: v = 32'(m_data_out);
            8'h04: v = 32'(m_dir);
            8'h08: v = 32'(m_pins[1]);
            8'h0C: v = 32'(m_irq_en);
            8'h10: v = 32'(m_status);
            8'h14: v = 32'(m_edge_sel);
            8'h30: v = 32'h4750_494F;
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_data_out = '0; m_dir = '0; m_irq_en = '0; m_edge_sel = '0; m_status = '0;
            m_pins[0] = '0; m_pins[1] = '0; m_pins[2] = '0;
            m_pend = 1'b0;
        end else begin
            m_hits = '0;
            for (int i = 0; i < GW; i++)
                if (m_pins[1][i] != m_pins[2][i] && m_pins[1][i] == m_edge_sel[i]) m_hits[i] = 1'b1;
            m_clr = '0;
            if (m_pend) begin
                case (m_pend_off)
                    8'h00: m_data_out = m_pend_data;
                    8'h04: m_dir      = m_pend_data;
                    8'h0C: m_irq_en   = m_pend_data;
                    8'h10: m_clr      = m_pend_data;
                    8'h14: m_edge_sel = m_pend_data;
                    default: ;
                endcase
            end
            m_status  = (m_status & ~m_clr) | m_hits;
            m_pins[2] = m_pins[1];
            m_pins[1] = m_pins[0];
            m_pins[0] = gpio_in;
            m_pend    = 1'b0;
        end
    end

    always @(negedge PCLK) begin
        if (cmp_on && !PRESET) begin
            chk("gpio_out", 32'(gpio_out), 32'(m_data_out));
            chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
            chk("irq", 32'(irq), 32'(|(m_status & m_irq_en)));
            if (!in_xfer) chk("pready_idle", 32'(PREADY), 32'd0);
        end
    end

    // Starts at a negedge with the setup phase; returns at a negedge with the bus released.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic erro);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          acc;
        in_xfer = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        exp_err = m_err(addr);
        exp_rd  = m_read(addr);
        @(negedge PCLK);
        PENABLE = 1'b1;
        acc = 1;
        while (!PREADY && acc <= 20) begin
            exp_rd = m_read(addr);
            @(negedge PCLK);
            acc++;
        end
        if (!PREADY) begin
            chk("pready_timeout", 32'(PREADY), 32'd1);
        end else begin
            chk("latency", 32'(acc), 32'(WS + 1));
            chk("pslverr", 32'(PSLVERR), 32'(exp_err));
            if (!wr) chk("prdata", PRDATA, exp_rd);
            if (wr && !exp_err) begin
                m_pend = 1'b1; m_pend_off = {addr[7:2], 2'b00}; m_pend_data = wd[GW-1:0];
            end
        end
        rdo = PRDATA; erro = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; in_xfer = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge PCLK);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_gpio_out", 32'(gpio_out), 32'd0);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        PRESET = 1'b0;
        cmp_on = 1'b1;
        @(negedge PCLK);

        xfer(1, 32'h04, 32'hFF, rd, err);
        xfer(1, 32'h00, 32'hA5, rd, err);
        chk("oe_ff", 32'(gpio_oe), 32'hFF);
        chk("out_a5", 32'(gpio_out), 32'hA5);

        gpio_in = 8'h3C;
        repeat (3) @(negedge PCLK);
        xfer(0, 32'h08, 0, rd, err);
        chk("data_in_3c", rd, 32'h0000_003C);
        chk("data_in_err", 32'(err), 32'd0);
        xfer(0, 32'h30, 0, rd, err);
        chk("id", rd, 32'h4750_494F);
        xfer(0, 32'h32, 0, rd, err);
        chk("id_low_bits", rd, 32'h4750_494F);

        xfer(1, 32'h14, 32'h01, rd, err);
        xfer(1, 32'h0C, 32'h01, rd, err);
        gpio_in = 8'h3D;
        repeat (2) @(negedge PCLK);
        chk("irq_before_3cyc", 32'(irq), 32'd0);
        @(negedge PCLK);
        chk("irq_at_3cyc", 32'(irq), 32'd1);
        xfer(0, 32'h10, 0, rd, err);
        chk("status_01", rd, 32'h01);
        xfer(1, 32'h10, 32'h01, rd, err);
        chk("irq_cleared", 32'(irq), 32'd0);

        gpio_in = 8'h3C;
        repeat (5) @(negedge PCLK);
        gpio_in = 8'h3D;
        xfer(1, 32'h10, 32'h01, rd, err);
        chk("set_wins_irq", 32'(irq), 32'd1);
        xfer(0, 32'h10, 0, rd, err);
        chk("set_wins_status", rd, 32'h01);
        xfer(1, 32'h10, 32'hFF, rd, err);

        xfer(0, 32'h20, 0, rd, err);
        chk("err20_slverr", 32'(err), 32'd1);
        chk("err20_prdata", rd, 32'd0);
        xfer(1, 32'h0000_0100, 32'h00, rd, err);
        chk("err100_slverr", 32'(err), 32'd1);
        chk("err100_no_write", 32'(gpio_out), 32'hA5);
        xfer(1, 32'h08, 32'hFF, rd, err);
        chk("ro_write_err", 32'(err), 32'd0);
        xfer(0, 32'h08, 0, rd, err);
        chk("ro_unchanged", rd, 32'h3D);
        xfer(1, 32'h04, 32'hFFFF_FF0F, rd, err);
        xfer(0, 32'h04, 0, rd, err);
        chk("upper_bits_zero", rd, 32'h0000_000F);

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h55;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_abort_out", 32'(gpio_out), 32'd0);
        chk("rst_abort_pready", 32'(PREADY), 32'd0);
        xfer(1, 32'h00, 32'h55, rd, err);
        chk("after_rst_write", 32'(gpio_out), 32'h55);

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h77;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b1;
        @(negedge PCLK);
        PENABLE = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("psel_drop_no_commit", 32'(gpio_out), 32'h55);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h99;
        repeat (4) @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("no_setup_ignored", 32'(gpio_out), 32'h55);
        xfer(0, 32'h00, 0, rd, err);
        chk("readback_55", rd, 32'h55);

        xfer(1, 32'h0C, 32'hFF, rd, err);
        gpio_in = 8'h00;
        repeat (4) @(negedge PCLK);
        xfer(0, 32'h10, 0, rd, err);
        chk("falling_status", rd, 32'h3D);
        xfer(0, 32'h08, 0, rd, err);
        chk("data_in_00", rd, 32'h00);
        chk("falling_irq", 32'(irq), 32'd1);
        repeat (2) @(negedge PCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
